// File: rtl/rvi_bj_redirect_ctrl.sv
// Branch/jump redirect controller: turns a resolved EX branch/jump into a
// registered fetch redirect, a flush window, link writeback and a misaligned-target trap.
module rvi_bj_redirect_ctrl #(
  parameter int RV64      = 0,
  parameter int CPU_WIDTH = 32 * (RV64 + 1),
  parameter bit SUPPORT_C = 1'b1,
  parameter int FLUSH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_vld,
  output logic                 ex_rdy,
  input  logic [1:0]           ex_bj_en,
  input  logic                 ex_is_jump,
  input  logic                 ex_rd_wen,
  input  logic [CPU_WIDTH-1:0] ex_tgt_addr,
  input  logic [CPU_WIDTH-1:0] ex_link_pc,
  output logic                 redir_vld,
  input  logic                 redir_rdy,
  output logic [CPU_WIDTH-1:0] redir_addr,
  output logic                 flush,
  output logic                 wb_vld,
  output logic [CPU_WIDTH-1:0] wb_data,
  output logic                 excp_vld,
  output logic [CPU_WIDTH-1:0] excp_tval,
  output logic [31:0]          taken_cnt
);

  typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 accept, taken, misaligned, go, wb_set;
  logic [CPU_WIDTH-1:0] tgt;

  assign accept     = ex_vld & ex_rdy;
  assign taken      = |ex_bj_en;
  // JAL/JALR targets have bit0 forced low before the alignment check
  assign tgt        = ex_is_jump ? {ex_tgt_addr[CPU_WIDTH-1:1], 1'b0} : ex_tgt_addr;
  assign misaligned = taken & (SUPPORT_C ? tgt[0] : |tgt[1:0]);
  assign go         = accept & taken & ~misaligned;
  assign wb_set     = accept & ex_is_jump & ex_rd_wen & ~misaligned;

  assign ex_rdy    = (state == IDLE);
  assign redir_vld = (state == REDIR);
  assign flush     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE:  if (go) state_nxt = REDIR;
      REDIR: if (redir_rdy) begin
        if (FLUSH_CYC == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = FLUSH;
          cnt_nxt   = FLUSH_INIT;
        end
      end
      FLUSH: if (cnt == 4'd0) state_nxt = IDLE;
             else cnt_nxt = cnt - 4'd1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      redir_addr <= '0;
      wb_vld     <= 1'b0;
      wb_data    <= '0;
      excp_vld   <= 1'b0;
      excp_tval  <= '0;
      taken_cnt  <= 32'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wb_vld   <= wb_set;
      excp_vld <= accept & misaligned;
      if (go) begin
        redir_addr <= tgt;
        taken_cnt  <= taken_cnt + 32'd1;
      end
      if (wb_set) wb_data <= ex_link_pc;
      if (accept & misaligned) excp_tval <= tgt;
    end
  end

endmodule

// File: tb/tb_rvi_bj_redirect_ctrl.sv
// Directed bench for rvi_bj_redirect_ctrl: three configurations share one stimulus
// stream; per-accept expectations are queued on drive and checked one cycle later.
module tb_rvi_bj_redirect_ctrl;

  localparam int W = 32;

  typedef struct packed {
    logic          ex_rdy;
    logic          redir_vld;
    logic [W-1:0]  redir_addr;
    logic          flush;
    logic          wb_vld;
    logic [W-1:0]  wb_data;
    logic          excp_vld;
    logic [W-1:0]  excp_tval;
    logic [31:0]   taken_cnt;
  } out_t;

  typedef struct {
    logic         rv;
    logic [W-1:0] ra;
    logic         wb;
    logic [W-1:0] wd;
    logic         ex;
    logic [W-1:0] tv;
    logic [31:0]  cnt;
  } exp_t;

  logic         clk = 1'b0, rst = 1'b1;
  logic         ex_vld = 1'b0, ex_is_jump = 1'b0, ex_rd_wen = 1'b0, redir_rdy = 1'b1;
  logic [1:0]   ex_bj_en = 2'b00;
  logic [W-1:0] ex_tgt_addr = '0, ex_link_pc = '0;
  out_t         o [3];
  exp_t         sbq [$];
  logic [31:0]  cnt_m [3];
  int           npass = 0, ntot = 0;

  always #5 clk = ~clk;

  // dut 0: C ext, 2 flush cycles; dut 1: no C ext; dut 2: C ext, no flush window
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit SC = (g != 1);
    localparam int FC = (g == 2) ? 0 : 2;
    logic         rdy, rv, fl, wv, xv;
    logic [W-1:0] ra, wd, tv;
    logic [31:0]  tc;
    rvi_bj_redirect_ctrl #(.RV64(0), .CPU_WIDTH(W), .SUPPORT_C(SC), .FLUSH_CYC(FC)) u_dut (
      .clk(clk), .rst(rst), .ex_vld(ex_vld), .ex_rdy(rdy), .ex_bj_en(ex_bj_en),
      .ex_is_jump(ex_is_jump), .ex_rd_wen(ex_rd_wen), .ex_tgt_addr(ex_tgt_addr),
      .ex_link_pc(ex_link_pc), .redir_vld(rv), .redir_rdy(redir_rdy), .redir_addr(ra),
      .flush(fl), .wb_vld(wv), .wb_data(wd), .excp_vld(xv), .excp_tval(tv), .taken_cnt(tc)
    );
    assign o[g] = '{ex_rdy: rdy, redir_vld: rv, redir_addr: ra, flush: fl, wb_vld: wv,
                    wb_data: wd, excp_vld: xv, excp_tval: tv, taken_cnt: tc};
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // drive one EX result for a single cycle; all DUTs must be idle
  task automatic issue(input logic [1:0] bj, input logic jmp, input logic wen,
                       input logic [W-1:0] t, input logic [W-1:0] l);
    exp_t e;
    logic [W-1:0] tg;
    logic mis, sc;
    ex_bj_en = bj; ex_is_jump = jmp; ex_rd_wen = wen; ex_tgt_addr = t; ex_link_pc = l;
    ex_vld = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sc  = (d != 1);
      tg  = jmp ? (t & ~32'h1) : t;
      mis = (|bj) & (sc ? tg[0] : |tg[1:0]);
      e.rv = (|bj) & ~mis; e.ra = tg;
      e.wb = jmp & wen & ~mis; e.wd = l;
      e.ex = mis; e.tv = tg;
      if (e.rv) cnt_m[d] = cnt_m[d] + 32'd1;
      e.cnt = cnt_m[d];
      sbq.push_back(e);
    end
    @(negedge clk);
    ex_vld = 1'b0;
    for (int d = 0; d < 3; d++) begin
      e = sbq.pop_front();
      chk($sformatf("d%0d redir_vld", d), W'(o[d].redir_vld), W'(e.rv));
      chk($sformatf("d%0d flush", d), W'(o[d].flush), W'(e.rv));
      if (e.rv) chk($sformatf("d%0d redir_addr", d), o[d].redir_addr, e.ra);
      chk($sformatf("d%0d wb_vld", d), W'(o[d].wb_vld), W'(e.wb));
      if (e.wb) chk($sformatf("d%0d wb_data", d), o[d].wb_data, e.wd);
      chk($sformatf("d%0d excp_vld", d), W'(o[d].excp_vld), W'(e.ex));
      if (e.ex) chk($sformatf("d%0d excp_tval", d), o[d].excp_tval, e.tv);
      chk($sformatf("d%0d taken_cnt", d), o[d].taken_cnt, e.cnt);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (o[0].ex_rdy & o[1].ex_rdy & o[2].ex_rdy) return;
      @(negedge clk);
    end
    chk("wait_idle", W'({o[0].ex_rdy, o[1].ex_rdy, o[2].ex_rdy}), W'(3'b111));
  endtask

  initial begin
    for (int d = 0; d < 3; d++) cnt_m[d] = 32'd0;
    #2;
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d reset_outputs", d), W'(o[d]), W'({1'b1, {($bits(out_t)-1){1'b0}}}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("d0 ex_rdy_after_reset", W'(o[0].ex_rdy), 32'd1);

    // JAL taken, fetch ready immediately
    redir_rdy = 1'b1;
    issue(2'b10, 1'b1, 1'b1, 32'h1001, 32'h204);
    chk("jal d0 ex_rdy N+1", W'(o[0].ex_rdy), 32'd0);
    @(negedge clk);
    chk("jal d0 flush N+2", W'(o[0].flush), 32'd1);
    chk("jal d0 redir_vld N+2", W'(o[0].redir_vld), 32'd0);
    chk("jal d0 wb_vld pulse end", W'(o[0].wb_vld), 32'd0);
    chk("jal d0 wb_data held", o[0].wb_data, 32'h204);
    chk("jal d2 ex_rdy N+2", W'(o[2].ex_rdy), 32'd1);
    chk("jal d2 flush N+2", W'(o[2].flush), 32'd0);
    @(negedge clk);
    chk("jal d0 flush N+3", W'(o[0].flush), 32'd1);
    chk("jal d0 ex_rdy N+3", W'(o[0].ex_rdy), 32'd0);
    @(negedge clk);
    chk("jal d0 ex_rdy N+4", W'(o[0].ex_rdy), 32'd1);
    chk("jal d0 flush N+4", W'(o[0].flush), 32'd0);
    wait_idle();

    // BLT taken while fetch stalls; EX pulses during the stall are ignored
    redir_rdy = 1'b0;
    issue(2'b01, 1'b0, 1'b0, 32'h80, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("stall c%0d redir_vld", k), W'(o[0].redir_vld), 32'd1);
      chk($sformatf("stall c%0d flush", k), W'(o[0].flush), 32'd1);
      chk($sformatf("stall c%0d redir_addr", k), o[0].redir_addr, 32'h80);
      ex_bj_en = 2'b10; ex_tgt_addr = 32'h200;
      ex_vld = (k < 5) && (k % 2 == 1);
      @(negedge clk);
    end
    chk("stall c6 redir_vld", W'(o[0].redir_vld), 32'd1);
    chk("stall c6 redir_addr", o[0].redir_addr, 32'h80);
    redir_rdy = 1'b1;
    @(negedge clk);
    chk("stall d0 redir_vld after hs", W'(o[0].redir_vld), 32'd0);
    chk("stall d0 flush after hs", W'(o[0].flush), 32'd1);
    chk("stall d2 ex_rdy after hs", W'(o[2].ex_rdy), 32'd1);
    chk("stall d0 taken_cnt", o[0].taken_cnt, cnt_m[0]);
    wait_idle();

    // not-taken results back to back
    for (int k = 0; k < 3; k++) begin
      issue(2'b00, 1'b0, 1'b0, 32'h44, 32'h0);
      chk($sformatf("nt%0d d0 ex_rdy", k), W'(o[0].ex_rdy), 32'd1);
    end

    // BEQ to a halfword-aligned target: trap without C, redirect with C
    issue(2'b10, 1'b0, 1'b0, 32'h102, 32'h0);
    @(negedge clk);
    chk("mis d1 excp_vld pulse end", W'(o[1].excp_vld), 32'd0);
    chk("mis d1 excp_tval held", o[1].excp_tval, 32'h102);
    chk("mis d1 ex_rdy", W'(o[1].ex_rdy), 32'd1);
    wait_idle();

    // misaligned JALR without C: no writeback
    issue(2'b10, 1'b1, 1'b1, 32'h1007, 32'h500);
    wait_idle();

    // taken_cnt wrap on the no-flush-window instance
    force g_dut[2].u_dut.taken_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release g_dut[2].u_dut.taken_cnt;
    cnt_m[2] = 32'hFFFF_FFFF;
    chk("wrap d2 preload", o[2].taken_cnt, 32'hFFFF_FFFF);
    issue(2'b10, 1'b1, 1'b1, 32'h2000, 32'h300);
    @(negedge clk);
    chk("wrap d2 ex_rdy after hs", W'(o[2].ex_rdy), 32'd1);
    wait_idle();

    // async reset in the middle of a stalled redirect
    redir_rdy = 1'b0;
    issue(2'b10, 1'b0, 1'b0, 32'h100, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst d0 redir_vld", W'(o[0].redir_vld), 32'd0);
    chk("rst d0 flush", W'(o[0].flush), 32'd0);
    chk("rst d0 redir_addr", o[0].redir_addr, 32'h0);
    chk("rst d0 wb_data", o[0].wb_data, 32'h0);
    chk("rst d0 taken_cnt", o[0].taken_cnt, 32'h0);
    chk("rst d1 excp_tval", o[1].excp_tval, 32'h0);
    chk("rst d0 ex_rdy", W'(o[0].ex_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    redir_rdy = 1'b1;
    @(negedge clk);
    chk("post rst d0 ex_rdy", W'(o[0].ex_rdy), 32'd1);
    chk("post rst d0 redir_vld", W'(o[0].redir_vld), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rvi_bj_redirect_ctrl.md
# rvi_bj_redirect_ctrl

Consumes the resolved branch/jump result from the RVI branch-jump execute stage (BjEn, target address, link PC) and turns it into a registered fetch redirect with a valid/ready handshake, a pipeline flush window, link-register writeback and a misaligned-target exception. It is the stage directly downstream of branch/jump execute and upstream of fetch, writeback and trap logic.

## Interface
- RV64, 0, 1 selects 64-bit datapath
- CPU_WIDTH, 32*(RV64+1), address/data width
- SUPPORT_C, 1, 1: targets need 2-byte alignment; 0: targets need 4-byte alignment
- FLUSH_CYC, 2, flush cycles after redirect is accepted (0..15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ex_vld  in  1  branch/jump instruction present in EX
- ex_rdy  out  1  block can accept EX result
- ex_bj_en  in  2  BjEn: [1] jump/beq/bne taken, [0] blt/bge taken
- ex_is_jump  in  1  instruction is JAL/JALR
- ex_rd_wen  in  1  jump writes rd
- ex_tgt_addr  in  CPU_WIDTH  computed target
- ex_link_pc  in  CPU_WIDTH  return address
- redir_vld  out  1  redirect request to fetch
- redir_rdy  in  1  fetch accepts redirect
- redir_addr  out  CPU_WIDTH  redirect target
- flush  out  1  kill younger instructions
- wb_vld  out  1  link writeback strobe
- wb_data  out  CPU_WIDTH  link value
- excp_vld  out  1  misaligned-target exception strobe
- excp_tval  out  CPU_WIDTH  faulting target
- taken_cnt  out  32  taken branch/jump count

## Operation
- Accept = ex_vld & ex_rdy; ex_rdy = (state == IDLE). ex_vld while ex_rdy=0 is ignored.
- taken = |ex_bj_en. Effective target: tgt = ex_tgt_addr with bit0 cleared when ex_is_jump, else ex_tgt_addr unchanged.
- misaligned = taken & (SUPPORT_C ? tgt[0] : |tgt[1:0]).
- States IDLE, REDIR, FLUSH.
  - IDLE, accept, taken & !misaligned: latch redir_addr=tgt, go REDIR; taken_cnt += 1 (wraps).
  - IDLE, accept, misaligned: excp_vld=1, excp_tval=tgt next cycle; stay IDLE; no redirect, no writeback, no count.
  - IDLE, accept, not taken: stay IDLE, no redirect.
  - REDIR: redir_vld=1, redir_addr stable until redir_vld & redir_rdy. On handshake: FLUSH_CYC>0 → FLUSH, counter=FLUSH_CYC-1; FLUSH_CYC=0 → IDLE.
  - FLUSH: counter decrements each cycle; at 0 → IDLE.
- flush = 1 in every REDIR and FLUSH cycle, else 0.
- Writeback: accept & ex_is_jump & ex_rd_wen & !misaligned → wb_vld=1, wb_data=ex_link_pc for one cycle, independent of redirect state.
- excp_tval, redir_addr, wb_data hold last value when their strobe is low.

## Timing
- Reset (async): state IDLE, ex_rdy=1 after deassertion, redir_vld=0, redir_addr=0, flush=0, wb_vld=0, wb_data=0, excp_vld=0, excp_tval=0, taken_cnt=0, counter=0.
- Accept at edge N: redir_vld, flush, wb_vld, excp_vld valid in cycle N+1 (1-cycle latency, registered outputs).
- redir_rdy high in cycle N+1: FLUSH for cycles N+2..N+1+FLUSH_CYC; ex_rdy=1 in cycle N+2+FLUSH_CYC.
- redir_rdy low: REDIR holds indefinitely; flush stays 1, redir_addr unchanged.
- wb_vld and excp_vld are single-cycle pulses; never both high.
- Back-to-back not-taken or misaligned results accepted every cycle.
- rst mid-REDIR/FLUSH: outputs return to reset values immediately; pending redirect dropped.

## Test plan
- Reset: rst=1 mid-REDIR with redir_addr=0x100 → all outputs 0 asynchronously, ex_rdy=1 after release.
- JAL taken: ex_bj_en=2'b10, ex_is_jump=1, ex_rd_wen=1, tgt=0x1001, link=0x204, redir_rdy=1 → N+1: redir_vld=1, redir_addr=0x1000, wb_vld=1, wb_data=0x204; flush N+1..N+3; ex_rdy back at N+4 (FLUSH_CYC=2); taken_cnt=1.
- BLT taken, fetch stalls: ex_bj_en=2'b01, tgt=0x80, redir_rdy=0 for 5 cycles → redir_vld, flush, redir_addr=0x80 held 5 cycles; ex_vld pulses ignored; handshake on 6th.
- Not taken: ex_bj_en=0, tgt=0x44 on 3 consecutive cycles → no redir_vld, no flush, ex_rdy=1 throughout, taken_cnt unchanged.
- Misaligned: SUPPORT_C=0, BEQ taken tgt=0x102 → N+1 excp_vld=1, excp_tval=0x102, no redirect/wb; SUPPORT_C=1 same tgt → redirect to 0x102.
- FLUSH_CYC=0 and taken_cnt wrap: preload 0xFFFFFFFF via 2^32 takes (or force), taken jump → taken_cnt=0; handshake cycle followed directly by ex_rdy=1.
